array_div: RTL and testbench

Six-lane signed fixed-point divider serving the inverse datapath. It is the responder on the dividend/divisor/quotient interface driven by the triangular-inverse sequencers. Each transaction divides six 27-bit Q10.16 dividends by one shared 27-bit divisor. All six quotients land in output registers a fixed, known number of cycles later, so the sequencer can sample them on a hard-coded count with no handshake.

---
 rtl/array_div_if.sv | 22 ++
 rtl/array_div.sv | 164 ++++++++++++++++
 tb/tb_array_div.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/array_div_if.sv
// Dividend/divisor/quotient interface between the triangular-inverse
// sequencer (master) and the six-lane divider (slave).
interface array_div_if #(
    parameter int QW = 36
);
    logic                 en;
    logic signed [26:0]   dividends [6];
    logic signed [26:0]   divisor;
    logic signed [QW-1:0] quotients [6];
    logic                 done;
    logic                 busy;

    modport master (
        output en, dividends, divisor,
        input  quotients, done, busy
    );

    modport slave (
        input  en, dividends, divisor,
        output quotients, done, busy
    );
endinterface

// File: rtl/array_div.sv
// Six-lane signed Q10.16 restoring divider with a fixed latency of STEPS
// iteration cycles after the request edge. All lanes share one divisor.
// Optional feature macro: ARRAY_DIV_SAT_EN (saturate results that do not
// fit in QW signed bits; otherwise the result wraps to the low QW bits).
module array_div #(
    parameter int STEPS         = 4,
    parameter int BITS_PER_STEP = 11,
    parameter int QW            = 36
) (
    input  logic       clk,
    input  logic       reset,
    array_div_if.slave bus
);
    localparam int LANES = 6;
    localparam int NW    = STEPS * BITS_PER_STEP;
    // Signed result width: one bit above the magnitude, and always wider than QW
    localparam int RW    = (NW + 1 > QW + 1) ? NW + 1 : QW + 1;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg;
    logic [CW-1:0]    step_reg;
    logic [26:0]      dmag_reg;
    logic [LANES-1:0] sign_reg;
    logic [NW-1:0]    num_reg  [LANES];
    logic [26:0]      rem_reg  [LANES];
    logic [QW-1:0]    quot_reg [LANES];
    logic             done_reg;
    logic             busy_reg;

    logic [26:0]      dmag_next;
    logic [LANES-1:0] sign_next;
    logic [NW-1:0]    load_num [LANES];
    logic [NW-1:0]    num_next [LANES];
    logic [26:0]      rem_next [LANES];
    logic [QW-1:0]    res_next [LANES];
    logic             last_step;

    assign last_step = (step_reg == CW'(STEPS - 1));

    // Shared divisor magnitude and per-lane result signs captured at request time
    always_comb begin
        dmag_next = bus.divisor[26] ? 27'(-bus.divisor) : 27'(bus.divisor);
        sign_next = '0;
        for (int l = 0; l < LANES; l++) begin
            sign_next[l] = bus.dividends[l][26] ^ bus.divisor[26];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [26:0]   dend_mag;
            logic [43:0]   dend_scaled;
            logic [NW-1:0] num_w;
            logic [26:0]   rem_w;
            logic [27:0]   trial;
            logic [RW-1:0] mag_ext;
            logic [RW-1:0] signed_res;
            logic [QW-1:0] res_w;

            // Dividend magnitude pre-scaled by 2^16 so the quotient keeps 16 fraction bits
            always_comb begin
                dend_mag    = bus.dividends[gi][26] ? 27'(-bus.dividends[gi])
                                                    : 27'(bus.dividends[gi]);
                dend_scaled = {17'd0, dend_mag} << 16;
            end

            // BITS_PER_STEP restoring iterations, MSB first; quotient bits shift into num_w
            always_comb begin
                num_w = num_reg[gi];
                rem_w = rem_reg[gi];
                trial = '0;
                for (int b = 0; b < BITS_PER_STEP; b++) begin
                    trial = {rem_w, num_w[NW-1]};
                    num_w = {num_w[NW-2:0], 1'b0};
                    if (trial >= {1'b0, dmag_reg}) begin
                        trial    = trial - {1'b0, dmag_reg};
                        num_w[0] = 1'b1;
                    end
                    rem_w = trial[26:0];
                end
            end

            // Apply lane sign, then fit the result into QW bits
            always_comb begin
                mag_ext    = RW'(num_w);
                signed_res = sign_reg[gi] ? -mag_ext : mag_ext;
`ifdef ARRAY_DIV_SAT_EN
                if ((&signed_res[RW-1:QW-1]) || !(|signed_res[RW-1:QW-1])) begin
                    res_w = signed_res[QW-1:0];
                end else if (signed_res[RW-1]) begin
                    res_w = {1'b1, {(QW-1){1'b0}}};
                end else begin
                    res_w = {1'b0, {(QW-1){1'b1}}};
                end
`else
                res_w = signed_res[QW-1:0];
`endif
            end

            assign load_num[gi]      = NW'(dend_scaled);
            assign num_next[gi]      = num_w;
            assign rem_next[gi]      = rem_w;
            assign res_next[gi]      = res_w;
            assign bus.quotients[gi] = quot_reg[gi];
        end
    endgenerate

    assign bus.done = done_reg;
    assign bus.busy = busy_reg;

    // Control FSM and lane state; everything freezes while en is low
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            step_reg  <= '0;
            dmag_reg  <= '0;
            sign_reg  <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                num_reg[l]  <= '0;
                rem_reg[l]  <= '0;
                quot_reg[l] <= '0;
            end
        end else if (bus.en) begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.divisor != '0) begin
                        dmag_reg  <= dmag_next;
                        sign_reg  <= sign_next;
                        step_reg  <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                        for (int l = 0; l < LANES; l++) begin
                            num_reg[l] <= load_num[l];
                            rem_reg[l] <= '0;
                        end
                    end
                end
                RUN: begin
                    step_reg <= step_reg + 1'b1;
                    for (int l = 0; l < LANES; l++) begin
                        num_reg[l] <= num_next[l];
                        rem_reg[l] <= rem_next[l];
                    end
                    if (last_step) begin
                        for (int l = 0; l < LANES; l++) begin
                            quot_reg[l] <= res_next[l];
                        end
                        step_reg  <= '0;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_array_div.sv
// Directed plus randomized bench for array_div: expected quotients come from
// plain 64-bit integer division of (dividend * 2^16) by the divisor.
module tb_array_div;
    localparam int LANES = 6;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cur_dd [LANES];
    int   cur_dv;
    logic [35:0] exp_q [LANES];

    array_div_if #(.QW(36)) bus ();

    array_div #(.STEPS(4), .BITS_PER_STEP(11), .QW(36)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] model_q(input int a, input int d);
        longint n;
        longint q;
        n = longint'(a) * 64'sd65536;
        q = n / longint'(d);
`ifdef ARRAY_DIV_SAT_EN
        if (q > 64'sd34359738367) q = 64'sd34359738367;
        else if (q < -64'sd34359738368) q = -64'sd34359738368;
`endif
        return q[35:0];
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_req();
        for (int i = 0; i < LANES; i++) bus.dividends[i] = 27'(cur_dd[i]);
        bus.divisor = 27'(cur_dv);
        bus.en      = 1'b1;
    endtask

    task automatic compute_exp();
        for (int i = 0; i < LANES; i++) exp_q[i] = model_q(cur_dd[i], cur_dv);
    endtask

    task automatic check_quot(input string tag);
        for (int i = 0; i < LANES; i++)
            chk($sformatf("%s q%0d", tag, i), bus.quotients[i], exp_q[i]);
    endtask

    task automatic set_ops(input int d0, input int d1, input int d2, input int d3,
                           input int d4, input int d5, input int dv);
        cur_dd[0] = d0; cur_dd[1] = d1; cur_dd[2] = d2;
        cur_dd[3] = d3; cur_dd[4] = d4; cur_dd[5] = d5;
        cur_dv    = dv;
    endtask

    // Full transaction: request at edge N, result and done checked after edge N+4
    task automatic run_txn(input string tag);
        drive_req();
        compute_exp();
        step();
        bus.divisor = '0;
        chk({tag, " busy@N"}, 36'(bus.busy), 36'd1);
        for (int k = 1; k < 4; k++) begin
            step();
            chk($sformatf("%s done@N+%0d", tag, k), 36'(bus.done), 36'd0);
            chk($sformatf("%s busy@N+%0d", tag, k), 36'(bus.busy), 36'd1);
        end
        step();
        chk({tag, " done@N+4"}, 36'(bus.done), 36'd1);
        chk({tag, " busy@N+4"}, 36'(bus.busy), 36'd0);
        check_quot(tag);
        step();
        chk({tag, " done@N+5"}, 36'(bus.done), 36'd0);
        $display("txn %s divisor=%0d q0=%0d q5=%0d", tag, cur_dv,
                 $signed(bus.quotients[0]), $signed(bus.quotients[5]));
    endtask

    function automatic int rand27();
        logic signed [26:0] t;
        case ($urandom_range(0, 7))
            0:       t = -27'sd67108864;
            1:       t = 27'sd67108863;
            2:       t = '0;
            3:       t = 27'($signed(9'($urandom)));
            default: t = 27'($urandom);
        endcase
        return int'(t);
    endfunction

    function automatic int rand_div();
        logic signed [26:0] t;
        if ($urandom_range(0, 3) == 0) t = 27'($signed(10'($urandom)));
        else t = 27'($urandom);
        if (t == 0) t = 27'sd1;
        return int'(t);
    endfunction

    initial begin
        reset       = 1'b1;
        bus.en      = 1'b0;
        bus.divisor = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.dividends[i] = '0;
            exp_q[i]         = '0;
        end
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        chk("reset busy", 36'(bus.busy), 36'd0);
        chk("reset done", 36'(bus.done), 36'd0);
        check_quot("reset");
        bus.en = 1'b1;
        step();

        // Identity
        set_ops(65536, 65536, 65536, 65536, 65536, 65536, 65536);
        run_txn("identity");

        // Mixed signs and truncation toward zero
        set_ops(65536, -196608, 0, -65536, 131072, 1, 196608);
        run_txn("mixed");

        // Overflow of the 36-bit result
        set_ops(67108863, -67108864, 0, -67108863, 1, -1, 1);
        run_txn("overflow");

        // Largest negative divisor
        set_ops(-67108864, 67108863, 123456, -7, 0, 65536, -67108864);
        run_txn("neg_divisor");

        // Stall: en low for edges N+2..N+4, done moves to N+7
        set_ops(300000, -300000, 65536, -1, 5000000, -5000000, -98304);
        drive_req();
        compute_exp();
        step();
        bus.divisor = '0;
        step();
        bus.en = 1'b0;
        repeat (3) step();
        chk("stall busy", 36'(bus.busy), 36'd1);
        chk("stall done", 36'(bus.done), 36'd0);
        bus.en = 1'b1;
        step();
        step();
        chk("stall done@N+6", 36'(bus.done), 36'd0);
        step();
        chk("stall done@N+7", 36'(bus.done), 36'd1);
        check_quot("stall");
        step();
        chk("stall done@N+8", 36'(bus.done), 36'd0);
        $display("txn stall divisor=%0d q0=%0d", cur_dv, $signed(bus.quotients[0]));

        // Zero divisor is not a request
        for (int i = 0; i < LANES; i++) bus.dividends[i] = 27'(1000 + i);
        bus.divisor = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("zero_div busy%0d", k), 36'(bus.busy), 36'd0);
            chk($sformatf("zero_div done%0d", k), 36'(bus.done), 36'd0);
        end
        check_quot("zero_div");
        $display("txn zero_div ignored");

        // Overlap: second request at N+2 is ignored
        set_ops(655360, -655360, 65536, 3, -3, 42, 131072);
        drive_req();
        compute_exp();
        step();
        bus.divisor = '0;
        step();
        for (int i = 0; i < LANES; i++) bus.dividends[i] = 27'(7 * 65536);
        bus.divisor = 27'(65536);
        step();
        bus.divisor = '0;
        step();
        step();
        chk("overlap done@N+4", 36'(bus.done), 36'd1);
        check_quot("overlap");
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("overlap no_done%0d", k), 36'(bus.done), 36'd0);
            chk($sformatf("overlap no_busy%0d", k), 36'(bus.busy), 36'd0);
        end
        check_quot("overlap hold");
        $display("txn overlap divisor=%0d q0=%0d", cur_dv, $signed(bus.quotients[0]));

        // Reset at edge N+2 aborts; fresh request at edge N+4
        set_ops(1, 2, 3, 4, 5, 6, 7);
        drive_req();
        step();
        bus.divisor = '0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < LANES; i++) exp_q[i] = '0;
        chk("abort busy", 36'(bus.busy), 36'd0);
        chk("abort done", 36'(bus.done), 36'd0);
        check_quot("abort");
        step();
        chk("abort done@N+3", 36'(bus.done), 36'd0);
        set_ops(-65536, 131072, -131072, 196608, 65536, 0, -65536);
        run_txn("after_abort");

        // Reset and request together: reset wins
        set_ops(65536, 65536, 65536, 65536, 65536, 65536, 65536);
        reset = 1'b1;
        drive_req();
        step();
        reset       = 1'b0;
        bus.divisor = '0;
        for (int i = 0; i < LANES; i++) exp_q[i] = '0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("coincide busy%0d", k), 36'(bus.busy), 36'd0);
            chk($sformatf("coincide done%0d", k), 36'(bus.done), 36'd0);
            step();
        end
        check_quot("coincide");
        $display("txn coincide reset_wins");

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < LANES; i++) cur_dd[i] = rand27();
            cur_dv = rand_div();
            run_txn($sformatf("rand%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
